// File: rtl/param_code_lock_pkg.sv
// Shared types and helpers for the parametrised keypad code lock.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package param_code_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    PROGRAM = 2'd2,
    LOCKOUT = 2'd3
  } lock_state_t;

  // Width of the shared down-counter. It is loaded with (cycles - 1), so
  // clog2 of the largest cycle count is enough.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/param_code_lock_if.sv
// Keypad-side and actuator-side signals of the code lock, bundled.
// Latency: n/a (wiring only).
// Backpressure: none; all inputs are single-cycle strobes with no ready.
// master: keypad decoder / test driver. slave: param_code_lock.
interface param_code_lock_if #(
  parameter int DIGIT_W  = 4,
  parameter int CODE_LEN = 4
);
  logic [DIGIT_W-1:0]              digit_in;
  logic                            digit_valid;
  logic                            enter;
  logic                            clear;
  logic                            prog_req;
  logic                            unlocked;
  logic                            lockout;
  logic                            fail_pulse;
  logic                            prog_done;
  logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt;

  modport master (
    output digit_in, digit_valid, enter, clear, prog_req,
    input  unlocked, lockout, fail_pulse, prog_done, digit_cnt
  );

  modport slave (
    input  digit_in, digit_valid, enter, clear, prog_req,
    output unlocked, lockout, fail_pulse, prog_done, digit_cnt
  );
endinterface

// File: rtl/param_code_lock_digit_shift_buf.sv
// Digit shift buffer: newest digit enters the LS slice, saturating count, overflow flag.
// Latency: 1 cycle (buffer, count and flag are registered).
// Backpressure: none; flush has priority over shift_en.
// Ports: clk, rst, flush, shift_en, din -> buf_dat, cnt, ovf.
module digit_shift_buf #(
  parameter int DIGIT_W  = 4,
  parameter int CODE_LEN = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            shift_en,
  input  logic [DIGIT_W-1:0]              din,
  output logic [CODE_LEN*DIGIT_W-1:0]     buf_dat,
  output logic [$clog2(CODE_LEN+1)-1:0]   cnt,
  output logic                            ovf
);
  localparam int CNT_W  = $clog2(CODE_LEN+1);
  localparam int CODE_W = CODE_LEN*DIGIT_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CODE_LEN);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      buf_dat <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else if (shift_en) begin
      // Shift keeps working past CODE_LEN; the overflow flag is what
      // makes such an entry unusable.
      buf_dat <= (buf_dat << DIGIT_W) | CODE_W'(din);
      if (cnt == FULL_CNT) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_code_lock.sv
// Keypad code lock: digit entry, compare on enter, lockout, entry timeout, unlock window, reprogramming.
// Latency: all outputs registered, valid the cycle after the causing input.
// Backpressure: none; inputs arriving in LOCKOUT or dropped by priority (clear > enter > digit) are lost.
// Ports: clk, rst (sync, active-high), bus (param_code_lock_if.slave).
module param_code_lock
  import param_code_lock_pkg::*;
#(
  parameter int                          DIGIT_W      = 4,
  parameter int                          CODE_LEN     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h0568,
  parameter int                          MAX_FAILS    = 3,
  parameter int                          LOCKOUT_CYC  = 1024,
  parameter int                          TIMEOUT_CYC  = 4096,
  parameter int                          UNLOCK_CYC   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  param_code_lock_if.slave     bus
);
  localparam int CNT_W  = $clog2(CODE_LEN+1);
  localparam int CODE_W = CODE_LEN*DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAILS+1);
  localparam int TMR_W  = timer_w(LOCKOUT_CYC, TIMEOUT_CYC, UNLOCK_CYC);

  localparam logic [CNT_W-1:0]  FULL_CNT     = CNT_W'(CODE_LEN);
  localparam logic [FAIL_W-1:0] LAST_FAIL    = FAIL_W'(MAX_FAILS-1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC-1);
  localparam logic [TMR_W-1:0]  TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC-1);
  localparam logic [TMR_W-1:0]  UNLOCK_LOAD  = TMR_W'(UNLOCK_CYC-1);

  lock_state_t          state;
  logic [CODE_W-1:0]    code_reg;
  logic [CODE_W-1:0]    buf_dat;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;
  logic [FAIL_W-1:0]    fail_cnt;
  logic [TMR_W-1:0]     timer;
  logic                 unlocked_q;
  logic                 lockout_q;
  logic                 fail_q;
  logic                 prog_q;

  logic                 entry_like;
  logic                 ent_act;
  logic                 dig_act;
  logic                 timeout_fire;
  logic                 full_ok;
  logic                 buf_flush;
  logic                 buf_shift;

  always_comb begin
    entry_like   = (state == ENTRY) || (state == PROGRAM);
    ent_act      = bus.enter && !bus.clear;
    dig_act      = bus.digit_valid && !bus.clear && !bus.enter;
    // Timer reaches zero only after TIMEOUT_CYC consecutive idle cycles
    // since the last accepted digit.
    timeout_fire = entry_like && (cnt != '0) && (timer == '0) &&
                   !bus.clear && !bus.enter && !bus.digit_valid;
    full_ok      = (cnt == FULL_CNT) && !ovf;
    // Outside ENTRY/PROGRAM the buffer is held empty.
    buf_flush    = !entry_like || bus.clear || ent_act || timeout_fire;
    buf_shift    = entry_like && dig_act;
  end

  digit_shift_buf #(
    .DIGIT_W  (DIGIT_W),
    .CODE_LEN (CODE_LEN)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (buf_flush),
    .shift_en (buf_shift),
    .din      (bus.digit_in),
    .buf_dat  (buf_dat),
    .cnt      (cnt),
    .ovf      (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENTRY;
      code_reg   <= DEFAULT_CODE;
      fail_cnt   <= '0;
      timer      <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      fail_q     <= 1'b0;
      prog_q     <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      prog_q <= 1'b0;
      case (state)
        ENTRY: begin
          if (bus.clear) begin
            // buffer flush only
          end else if (bus.enter) begin
            if (full_ok && (buf_dat == code_reg)) begin
              state      <= OPEN;
              timer      <= UNLOCK_LOAD;
              fail_cnt   <= '0;
              unlocked_q <= 1'b1;
            end else begin
              fail_q   <= 1'b1;
              fail_cnt <= fail_cnt + 1'b1;
              if (fail_cnt == LAST_FAIL) begin
                state     <= LOCKOUT;
                timer     <= LOCKOUT_LOAD;
                lockout_q <= 1'b1;
              end
            end
          end else if (bus.digit_valid) begin
            timer <= TIMEOUT_LOAD;
          end else if ((cnt != '0) && (timer != '0)) begin
            timer <= timer - 1'b1;
          end
        end

        OPEN: begin
          // clear outranks enter, so clear+enter keeps the lock open;
          // a program request in the final open cycle still wins over expiry.
          if (ent_act) begin
            state      <= ENTRY;
            unlocked_q <= 1'b0;
          end else if (bus.prog_req) begin
            state      <= PROGRAM;
            unlocked_q <= 1'b0;
          end else if (timer == '0) begin
            state      <= ENTRY;
            unlocked_q <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        PROGRAM: begin
          if (bus.clear) begin
            state <= ENTRY;
          end else if (bus.enter) begin
            if (full_ok) begin
              code_reg <= buf_dat;
              prog_q   <= 1'b1;
            end
            state <= ENTRY;
          end else if (bus.digit_valid) begin
            timer <= TIMEOUT_LOAD;
          end else if (timeout_fire) begin
            state <= ENTRY;
          end else if ((cnt != '0) && (timer != '0)) begin
            timer <= timer - 1'b1;
          end
        end

        LOCKOUT: begin
          if (timer == '0) begin
            state     <= ENTRY;
            fail_cnt  <= '0;
            lockout_q <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state <= ENTRY;
        end
      endcase
    end
  end

  assign bus.unlocked   = unlocked_q;
  assign bus.lockout    = lockout_q;
  assign bus.fail_pulse = fail_q;
  assign bus.prog_done  = prog_q;
  assign bus.digit_cnt  = cnt;

endmodule

// File: tb/tb_param_code_lock.sv
// Testbench for param_code_lock with short timers; queue-based reference model.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: n/a.
module tb_param_code_lock;
  localparam int DW = 4;
  localparam int L  = 4;
  localparam int MF = 3;
  localparam int LC = 16;
  localparam int TC = 32;
  localparam int UC = 8;
  localparam logic [L*DW-1:0] DEF_CODE = 16'h0568;

  localparam int M_ENTRY = 0;
  localparam int M_OPEN  = 1;
  localparam int M_PROG  = 2;
  localparam int M_LOCK  = 3;

  logic clk;
  logic rst;
  param_code_lock_if #(.DIGIT_W(DW), .CODE_LEN(L)) bus ();

  param_code_lock #(
    .DIGIT_W(DW), .CODE_LEN(L), .DEFAULT_CODE(DEF_CODE), .MAX_FAILS(MF),
    .LOCKOUT_CYC(LC), .TIMEOUT_CYC(TC), .UNLOCK_CYC(UC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  int m_mode;
  int m_q[$];
  int m_code[L];
  int m_fails;
  int m_idle;
  int m_elapsed;
  bit e_fail;
  bit e_prog;

  task automatic model_reset();
    logic [L*DW-1:0] c;
    c = DEF_CODE;
    m_mode = M_ENTRY;
    m_q.delete();
    for (int i = 0; i < L; i++) m_code[i] = int'((c >> (DW*(L-1-i))) & 16'hF);
    m_fails = 0; m_idle = 0; m_elapsed = 0;
    e_fail = 0; e_prog = 0;
  endtask

  function automatic bit q_is_code();
    if (m_q.size() != L) return 0;
    for (int i = 0; i < L; i++) if (m_q[i] != m_code[i]) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit dv, input int d, input bit en, input bit cl, input bit pr);
    e_fail = 0;
    e_prog = 0;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_ENTRY, M_PROG: begin
        if (cl) begin
          m_q.delete();
          m_mode = M_ENTRY;
        end else if (en) begin
          if (m_mode == M_ENTRY) begin
            if (q_is_code()) begin
              m_mode = M_OPEN; m_elapsed = 0; m_fails = 0;
            end else begin
              e_fail = 1;
              m_fails++;
              if (m_fails == MF) begin m_mode = M_LOCK; m_elapsed = 0; end
            end
          end else begin
            if (m_q.size() == L) begin
              for (int i = 0; i < L; i++) m_code[i] = m_q[i];
              e_prog = 1;
            end
            m_mode = M_ENTRY;
          end
          m_q.delete();
        end else if (dv) begin
          m_q.push_back(d);
          if (m_q.size() > L + 1) void'(m_q.pop_front());
          m_idle = 0;
        end else if (m_q.size() > 0) begin
          m_idle++;
          if (m_idle == TC) begin
            m_q.delete();
            m_mode = M_ENTRY;
          end
        end
      end
      M_OPEN: begin
        if (en && !cl) m_mode = M_ENTRY;
        else if (pr) m_mode = M_PROG;
        else begin
          m_elapsed++;
          if (m_elapsed == UC) m_mode = M_ENTRY;
        end
      end
      default: begin
        m_elapsed++;
        if (m_elapsed == LC) begin m_mode = M_ENTRY; m_fails = 0; end
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("unlocked",   32'(bus.unlocked),   32'(m_mode == M_OPEN));
      chk("lockout",    32'(bus.lockout),    32'(m_mode == M_LOCK));
      chk("fail_pulse", 32'(bus.fail_pulse), 32'(e_fail));
      chk("prog_done",  32'(bus.prog_done),  32'(e_prog));
      chk("digit_cnt",  32'(bus.digit_cnt),  32'((m_q.size() > L) ? L : m_q.size()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input bit dv, input int d, input bit en, input bit cl, input bit pr);
    bus.digit_valid = dv;
    bus.digit_in    = DW'(d);
    bus.enter       = en;
    bus.clear       = cl;
    bus.prog_req    = pr;
    @(posedge clk);
    model_step(dv, d, en, cl, pr);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic key4(input int a, input int b, input int c, input int e);
    cycle(1, a, 0, 0, 0); cycle(1, b, 0, 0, 0);
    cycle(1, c, 0, 0, 0); cycle(1, e, 0, 0, 0);
  endtask

  task automatic do_enter();
    cycle(0, 0, 1, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hi;
    int lk;
    model_reset();
    rst = 1'b1;
    bus.digit_valid = 0; bus.digit_in = '0; bus.enter = 0; bus.clear = 0; bus.prog_req = 0;
    cycle(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cycle(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_unlocked", 32'(bus.unlocked), 0);
    chk("rst_lockout",  32'(bus.lockout), 0);
    chk("rst_cnt",      32'(bus.digit_cnt), 0);

    // correct default code -> 8-cycle unlock window
    key4(0, 5, 6, 8); do_enter();
    chk("unlock_first", 32'(bus.unlocked), 1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.unlocked) hi++;
      idle(1);
    end
    chk("unlock_len", 32'(hi), 8);

    // three wrong codes -> lockout for 16 cycles, digits ignored
    for (int k = 0; k < 3; k++) begin
      key4(0, 5, 6, 9); do_enter();
      chk("wrong_fail", 32'(bus.fail_pulse), 1);
    end
    chk("lock_first", 32'(bus.lockout), 1);
    lk = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.lockout) begin
        lk++;
        chk("lock_cnt", 32'(bus.digit_cnt), 0);
      end
      cycle(1, 3, 0, 0, 0);
    end
    chk("lock_len", 32'(lk), 16);
    cycle(0, 0, 0, 1, 0);

    // overflow entry rejected
    key4(0, 5, 6, 8); cycle(1, 8, 0, 0, 0); do_enter();
    chk("ovf_fail", 32'(bus.fail_pulse), 1);
    chk("ovf_locked", 32'(bus.unlocked), 0);

    // entry timeout
    cycle(1, 0, 0, 0, 0); cycle(1, 5, 0, 0, 0);
    idle(31);
    chk("tmo_hold", 32'(bus.digit_cnt), 2);
    idle(1);
    chk("tmo_clear", 32'(bus.digit_cnt), 0);
    key4(0, 5, 6, 8); do_enter();
    chk("tmo_unlock", 32'(bus.unlocked), 1);

    // reprogram to 1,2,3,4
    cycle(0, 0, 0, 0, 1);
    chk("prog_drop", 32'(bus.unlocked), 0);
    key4(1, 2, 3, 4); do_enter();
    chk("prog_done", 32'(bus.prog_done), 1);
    idle(1);
    chk("prog_one", 32'(bus.prog_done), 0);
    key4(0, 5, 6, 8); do_enter();
    chk("old_fail", 32'(bus.fail_pulse), 1);
    key4(1, 2, 3, 4); do_enter();
    chk("new_unlock", 32'(bus.unlocked), 1);
    do_enter();
    chk("relock", 32'(bus.unlocked), 0);

    // clear+enter+digit together with full buffer
    key4(1, 2, 3, 4);
    chk("full_cnt", 32'(bus.digit_cnt), 4);
    cycle(1, 7, 1, 1, 0);
    chk("prio_cnt", 32'(bus.digit_cnt), 0);
    chk("prio_nofail", 32'(bus.fail_pulse), 0);

    // reset while open drops the programmed code
    key4(1, 2, 3, 4); do_enter();
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_open", 32'(bus.unlocked), 0);
    key4(0, 5, 6, 8); do_enter();
    chk("rst_default", 32'(bus.unlocked), 1);

    // randomized attempts
    for (int a = 0; a < 200; a++) begin
      int kind;
      int n;
      int sel;
      int d;
      kind = $urandom_range(0, 9);
      if (m_mode == M_OPEN && $urandom_range(0, 1) == 1) cycle(0, 0, 0, 0, 1);
      n = (kind < 4) ? L : $urandom_range(0, L + 2);
      for (int i = 0; i < n; i++) begin
        d = (kind < 4) ? m_code[i] : $urandom_range(0, 15);
        if (kind < 4 && $urandom_range(0, 9) == 0) d = $urandom_range(0, 15);
        cycle(1, d, 0, 0, 0);
        repeat ($urandom_range(0, 2)) cycle(0, 0, 0, 0, $urandom_range(0, 9) == 0);
      end
      if (kind == 9) idle(TC + 2);
      sel = $urandom_range(0, 39);
      if (sel == 0) begin
        rst = 1'b1; cycle(0, 0, 0, 0, 0); rst = 1'b0;
      end else if (sel < 5) cycle(0, 0, 0, 1, 0);
      else if (sel < 9) cycle($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                              $urandom_range(0, 1), $urandom_range(0, 1));
      else do_enter();
      repeat ($urandom_range(0, 12))
        cycle($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 9) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
